// File: rtl/seq_control.sv
// Instruction sequencer: HALT/FETCH/DECODE/EXECUTE control with fetch
// timeout watchdog, gated decoder strobes and a retired-instruction counter.
module seq_control #(
   parameter int PC_WIDTH          = 8,
   parameter int PROGRAM_DataWidth = 16,
   parameter int FETCH_TIMEOUT     = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   input  logic                         step,
   input  logic [PC_WIDTH-1:0]          pc,
   output logic                         imem_req,
   output logic [PC_WIDTH-1:0]          imem_addr,
   input  logic                         imem_ack,
   input  logic [PROGRAM_DataWidth-1:0] imem_data,
   output logic [PROGRAM_DataWidth-1:0] instr,
   input  logic                         dec_wr_en,
   input  logic                         dec_cnt_wr_en,
   input  logic                         dec_stat_wr_en,
   output logic                         reg_wr_en,
   output logic                         pc_wr_en,
   output logic                         stat_wr_en,
   output logic                         pc_inc,
   output logic [2:0]                   state,
   output logic                         halted,
   output logic                         fault,
   output logic [15:0]                  instr_cnt
);

   localparam logic [2:0] S_HALT   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_FAULT  = 3'd4;

   localparam int          TW      = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

   logic [2:0]                   r_state;
   logic [PROGRAM_DataWidth-1:0] r_instr;
   logic [15:0]                  r_cnt;
   logic [TW-1:0]                r_to;
   logic                         w_fetch;
   logic                         w_exec;

   // r_to holds the number of FETCH cycles already spent without an ack;
   // it is forced to zero outside FETCH so every entry starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HALT;
         r_instr <= '0;
         r_cnt   <= '0;
         r_to    <= '0;
      end else begin
         r_to <= '0;
         case (r_state)
            S_HALT: begin
               if (run || step) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_instr <= imem_data;
                  r_state <= S_DECODE;
               end else if (r_to == TO_LAST) begin
                  r_state <= S_FAULT;
               end else begin
                  r_to <= r_to + TW'(1);
               end
            end
            S_DECODE: r_state <= S_EXEC;
            S_EXEC: begin
               r_cnt   <= r_cnt + 16'd1;
               r_state <= run ? S_FETCH : S_HALT;
            end
            S_FAULT: r_state <= S_FAULT;
            default: r_state <= S_FAULT;
         endcase
      end
   end

   assign w_fetch = (r_state == S_FETCH);
   assign w_exec  = (r_state == S_EXEC);

   assign imem_req   = w_fetch;
   assign imem_addr  = w_fetch ? pc : '0;
   assign reg_wr_en  = w_exec & dec_wr_en;
   assign stat_wr_en = w_exec & dec_stat_wr_en;
   assign pc_wr_en   = w_exec & dec_cnt_wr_en;
   assign pc_inc     = w_exec & ~dec_cnt_wr_en;
   assign instr      = r_instr;
   assign state      = r_state;
   assign halted     = (r_state == S_HALT);
   assign fault      = (r_state == S_FAULT);
   assign instr_cnt  = r_cnt;

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control: run/step sequencing, fetch wait and
// timeout, strobe gating, fault lock-up and asynchronous reset abort.
module tb_seq_control;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        step;
   logic [7:0]  pc;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        dec_wr_en;
   logic        dec_cnt_wr_en;
   logic        dec_stat_wr_en;
   logic        reg_wr_en;
   logic        pc_wr_en;
   logic        stat_wr_en;
   logic        pc_inc;
   logic [2:0]  state;
   logic        halted;
   logic        fault;
   logic [15:0] instr_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_req   = 0;
   int req0;

   seq_control dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .run            (run),
      .step           (step),
      .pc             (pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_data      (imem_data),
      .instr          (instr),
      .dec_wr_en      (dec_wr_en),
      .dec_cnt_wr_en  (dec_cnt_wr_en),
      .dec_stat_wr_en (dec_stat_wr_en),
      .reg_wr_en      (reg_wr_en),
      .pc_wr_en       (pc_wr_en),
      .stat_wr_en     (stat_wr_en),
      .pc_inc         (pc_inc),
      .state          (state),
      .halted         (halted),
      .fault          (fault),
      .instr_cnt      (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (imem_req) n_req++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic strobes0(input string tag);
      chk({tag, "_reg"}, 32'(reg_wr_en), 0);
      chk({tag, "_stat"}, 32'(stat_wr_en), 0);
      chk({tag, "_pcw"}, 32'(pc_wr_en), 0);
      chk({tag, "_inc"}, 32'(pc_inc), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; run = 0; step = 0; pc = 8'h55;
      imem_ack = 0; imem_data = 16'hFFFF;
      dec_wr_en = 1; dec_cnt_wr_en = 0; dec_stat_wr_en = 1;
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_halted", 32'(halted), 1);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_cnt", 32'(instr_cnt), 0);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_addr", 32'(imem_addr), 0);
      strobes0("rst");

      @(negedge clk); rst_n = 1;
      cyc(); cyc();
      chk("idle_state", 32'(state), 0);
      chk("idle_req", 32'(imem_req), 0);

      // ADD with zero-wait memory, then GOTO while run drops mid-instruction
      run = 1; imem_ack = 1; imem_data = 16'h0A90; pc = 8'h10;
      dec_wr_en = 1; dec_stat_wr_en = 1; dec_cnt_wr_en = 0;
      cyc();
      chk("add_fetch", 32'(state), 1);
      chk("add_req", 32'(imem_req), 1);
      chk("add_addr", 32'(imem_addr), 32'h10);
      strobes0("add_f");
      cyc();
      chk("add_dec", 32'(state), 2);
      chk("add_instr", 32'(instr), 32'h0A90);
      chk("add_dreq", 32'(imem_req), 0);
      chk("add_daddr", 32'(imem_addr), 0);
      strobes0("add_d");
      cyc();
      chk("add_exec", 32'(state), 3);
      chk("add_reg", 32'(reg_wr_en), 1);
      chk("add_stat", 32'(stat_wr_en), 1);
      chk("add_inc", 32'(pc_inc), 1);
      chk("add_pcw", 32'(pc_wr_en), 0);
      imem_data = 16'h4012;
      dec_wr_en = 0; dec_stat_wr_en = 0; dec_cnt_wr_en = 1;
      cyc();
      chk("add_refetch", 32'(state), 1);
      chk("add_cnt", 32'(instr_cnt), 1);
      chk("add_instr_hold", 32'(instr), 32'h0A90);
      run = 0;
      cyc();
      chk("goto_instr", 32'(instr), 32'h4012);
      cyc();
      chk("goto_exec", 32'(state), 3);
      chk("goto_pcw", 32'(pc_wr_en), 1);
      chk("goto_inc", 32'(pc_inc), 0);
      chk("goto_reg", 32'(reg_wr_en), 0);
      cyc();
      chk("goto_halt", 32'(state), 0);
      chk("goto_halted", 32'(halted), 1);
      chk("goto_cnt", 32'(instr_cnt), 2);

      // single step; a second step pulse during DECODE is ignored
      step = 1; imem_data = 16'h1234;
      dec_wr_en = 1; dec_cnt_wr_en = 0;
      cyc();
      chk("stp_fetch", 32'(state), 1);
      step = 0;
      cyc();
      chk("stp_dec", 32'(state), 2);
      step = 1;
      cyc();
      step = 0;
      chk("stp_exec", 32'(state), 3);
      chk("stp_reg", 32'(reg_wr_en), 1);
      cyc();
      chk("stp_halt", 32'(halted), 1);
      chk("stp_cnt", 32'(instr_cnt), 3);
      cyc();
      chk("stp_stay", 32'(state), 0);

      // ack delayed three cycles
      run = 1; imem_ack = 0; imem_data = 16'hABCD;
      req0 = n_req;
      cyc();
      for (int i = 0; i < 3; i++) begin
         chk("dly_state", 32'(state), 1);
         chk("dly_instr", 32'(instr), 32'h1234);
         strobes0("dly");
         cyc();
      end
      chk("dly_c4", 32'(state), 1);
      imem_ack = 1;
      run = 0;
      cyc();
      chk("dly_dec", 32'(state), 2);
      chk("dly_instr_new", 32'(instr), 32'hABCD);
      chk("dly_reqcnt", 32'(n_req - req0), 4);
      cyc(); cyc();
      chk("dly_halt", 32'(state), 0);
      chk("dly_cnt", 32'(instr_cnt), 4);

      // ack in the last allowed FETCH cycle is accepted
      run = 1; imem_ack = 0; imem_data = 16'h5A5A;
      cyc();
      for (int i = 1; i < 15; i++) cyc();
      chk("to15_fetch", 32'(state), 1);
      imem_ack = 1; run = 0;
      cyc();
      chk("to15_dec", 32'(state), 2);
      chk("to15_instr", 32'(instr), 32'h5A5A);
      cyc(); cyc();
      chk("to15_cnt", 32'(instr_cnt), 5);

      // no ack at all: FAULT after 15 FETCH cycles, then lock-up
      run = 1; imem_ack = 0;
      cyc();
      for (int i = 1; i < 15; i++) cyc();
      chk("flt_c15", 32'(state), 1);
      cyc();
      chk("flt_state", 32'(state), 4);
      chk("flt_fault", 32'(fault), 1);
      chk("flt_req", 32'(imem_req), 0);
      chk("flt_halted", 32'(halted), 0);
      for (int i = 0; i < 4; i++) begin
         step = (i % 2 == 0);
         imem_ack = 1;
         cyc();
      end
      step = 0;
      chk("flt_stuck", 32'(state), 4);
      strobes0("flt");
      chk("flt_cnt", 32'(instr_cnt), 5);

      // reset asserted mid-EXECUTE aborts without a strobe
      #1 rst_n = 0;
      #1 chk("flt_rst", 32'(state), 0);
      @(negedge clk); rst_n = 1;
      run = 1; imem_ack = 1; dec_wr_en = 1; dec_stat_wr_en = 1;
      cyc(); cyc(); cyc();
      chk("rx_exec", 32'(state), 3);
      chk("rx_reg", 32'(reg_wr_en), 1);
      #1 rst_n = 0;
      #1;
      strobes0("rx");
      chk("rx_state", 32'(state), 0);
      chk("rx_cnt", 32'(instr_cnt), 0);
      chk("rx_instr", 32'(instr), 0);
      chk("rx_req", 32'(imem_req), 0);
      run = 0;
      @(negedge clk); rst_n = 1;
      cyc(); cyc();
      chk("rx_idle", 32'(state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
